obi_rr_arbiter: RTL and testbench

Two-requester OBI arbiter that shares one OBI master port, the bus-side data port, between the AXI-to-OBI bridge and the core data port. Requests are granted round-robin. Up to `MaxOutstanding` accepted transactions are tracked in order, so each response (`rvalid`/`rdata`) is routed back to the requester that issued it. The block sits between the two requesters and the system bus crossbar slave port.

---
 rtl/obi_rr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_obi_rr_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : obi_rr_arbiter
// Purpose  : Two-requester round-robin OBI arbiter sharing one OBI master
//            port between the AXI-to-OBI bridge (index 0) and the core data
//            port (index 1). Accepted transactions are tracked in an
//            in-order ID FIFO so every response is routed to its issuer.
// Ports    : clk_i, rst_ni         clock, synchronous active-low reset
//            req_i/gnt_o           per-requester OBI handshake
//            addr_i/we_i/be_i/wdata_i   per-requester address phase
//            rvalid_o/rdata_o      per-requester response phase
//            m_*                   shared OBI master port
//            outstanding_o         number of in-flight transactions
//            err_o                 sticky: response with nothing in flight
// Revision : 1.0 - initial release
// ============================================================================
module obi_rr_arbiter #(
  parameter int AddrWidth      = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [1:0]                           req_i,
  output logic [1:0]                           gnt_o,
  input  logic [1:0][AddrWidth-1:0]            addr_i,
  input  logic [1:0]                           we_i,
  input  logic [1:0][3:0]                      be_i,
  input  logic [1:0][31:0]                     wdata_i,
  output logic [1:0]                           rvalid_o,
  output logic [1:0][31:0]                     rdata_o,
  output logic                                 m_req_o,
  input  logic                                 m_gnt_i,
  output logic [AddrWidth-1:0]                 m_addr_o,
  output logic                                 m_we_o,
  output logic [3:0]                           m_be_o,
  output logic [31:0]                          m_wdata_o,
  input  logic                                 m_rvalid_i,
  input  logic [31:0]                          m_rdata_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic                                 err_o
);

  localparam int c_cnt_w = $clog2(MaxOutstanding + 1);
  localparam int c_ptr_w = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [c_ptr_w-1:0] c_ptr_max = c_ptr_w'(MaxOutstanding - 1);
  localparam logic [c_cnt_w-1:0] c_max_cnt = c_cnt_w'(MaxOutstanding);

  logic                r_prio;
  logic                r_lock_valid;
  logic                r_lock_id;
  logic                r_fifo [MaxOutstanding];
  logic [c_ptr_w-1:0]  r_rptr;
  logic [c_ptr_w-1:0]  r_wptr;
  logic [c_cnt_w-1:0]  r_count;
  logic                r_err;

  logic                w_sel;
  logic                w_issue;
  logic                w_accept;
  logic                w_pop;
  logic                w_head;

  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_max) ? '0 : p + 1'b1;
  endfunction

  // Selection: a stalled request keeps its slot until granted so the
  // address phase cannot change under the slave.
  always_comb begin
    w_sel = 1'b0;
    if (r_lock_valid) begin
      w_sel = r_lock_id;
    end else begin
      unique case (req_i)
        2'b01:   w_sel = 1'b0;
        2'b10:   w_sel = 1'b1;
        2'b11:   w_sel = r_prio;
        default: w_sel = 1'b0;
      endcase
    end
  end

  // A full FIFO blocks issue even if a pop happens this cycle, which keeps
  // m_rvalid_i out of the request/grant path.
  assign w_issue  = rst_ni & req_i[w_sel] & (r_count < c_max_cnt);
  assign w_accept = w_issue & m_gnt_i;
  assign w_pop    = rst_ni & m_rvalid_i & (r_count != '0);
  assign w_head   = r_fifo[r_rptr];

  always_comb begin
    m_req_o   = w_issue;
    m_addr_o  = '0;
    m_we_o    = 1'b0;
    m_be_o    = '0;
    m_wdata_o = '0;
    gnt_o     = '0;
    rvalid_o  = '0;
    rdata_o   = '0;
    if (w_issue) begin
      m_addr_o  = addr_i[w_sel];
      m_we_o    = we_i[w_sel];
      m_be_o    = be_i[w_sel];
      m_wdata_o = wdata_i[w_sel];
    end
    if (w_accept) begin
      gnt_o[w_sel] = 1'b1;
    end
    if (w_pop) begin
      rvalid_o[w_head] = 1'b1;
      rdata_o[w_head]  = m_rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_prio       <= 1'b0;
      r_lock_valid <= 1'b0;
      r_lock_id    <= 1'b0;
      r_rptr       <= '0;
      r_wptr       <= '0;
      r_count      <= '0;
      r_err        <= 1'b0;
      for (int i = 0; i < MaxOutstanding; i++) begin
        r_fifo[i] <= 1'b0;
      end
    end else begin
      if (w_accept) begin
        r_fifo[r_wptr] <= w_sel;
        r_wptr         <= ptr_inc(r_wptr);
        r_prio         <= ~w_sel;
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      unique case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_accept) begin
        r_lock_valid <= 1'b0;
      end else if (w_issue) begin
        r_lock_valid <= 1'b1;
        r_lock_id    <= w_sel;
      end else if (r_lock_valid && !req_i[r_lock_id]) begin
        // Requester withdrew a stalled request; release the slot.
        r_lock_valid <= 1'b0;
      end

      if (m_rvalid_i && (r_count == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign outstanding_o = r_count;
  assign err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_obi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_obi_rr_arbiter
// Purpose  : Directed self-checking bench for obi_rr_arbiter (default
//            parameters: 32-bit address, two outstanding transactions).
// Revision : 1.0 - initial release
// ============================================================================
module tb_obi_rr_arbiter;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [1:0]        req_i;
  logic [1:0]        gnt_o;
  logic [1:0][31:0]  addr_i;
  logic [1:0]        we_i;
  logic [1:0][3:0]   be_i;
  logic [1:0][31:0]  wdata_i;
  logic [1:0]        rvalid_o;
  logic [1:0][31:0]  rdata_o;
  logic              m_req_o;
  logic              m_gnt_i;
  logic [31:0]       m_addr_o;
  logic              m_we_o;
  logic [3:0]        m_be_o;
  logic [31:0]       m_wdata_o;
  logic              m_rvalid_i;
  logic [31:0]       m_rdata_i;
  logic [1:0]        outstanding_o;
  logic              err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  obi_rr_arbiter #(.AddrWidth(32), .MaxOutstanding(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_i(req_i), .gnt_o(gnt_o),
    .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .m_req_o(m_req_o), .m_gnt_i(m_gnt_i), .m_addr_o(m_addr_o),
    .m_we_o(m_we_o), .m_be_o(m_be_o), .m_wdata_o(m_wdata_o),
    .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; req_i = 2'b11; m_gnt_i = 1'b1; m_rvalid_i = 1'b1;
    tick(); tick();
    #1;
    checks++;
    if (gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b exp 00", gnt_o); end
    checks++;
    if (m_req_o !== 1'b0) begin errors++; $display("FAIL reset_mreq got %b exp 0", m_req_o); end
    checks++;
    if (rvalid_o !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b exp 00", rvalid_o); end
    tick();
    rst_ni = 1'b1; m_rvalid_i = 1'b0;
    #1;
    checks++;
    if (outstanding_o !== 2'd0) begin errors++; $display("FAIL reset_outstanding got %0d exp 0", outstanding_o); end
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_o); end
    checks++;
    if (gnt_o !== 2'b01) begin errors++; $display("FAIL reset_first_gnt got %b exp 01", gnt_o); end
    req_i = 2'b00; m_gnt_i = 1'b0;
    #1;
    checks++;
    if (m_addr_o !== 32'h0) begin errors++; $display("FAIL idle_addr_zero got %h exp 0", m_addr_o); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_gnt [4];
    logic [31:0] exp_addr [4];
    logic [1:0]  prev;
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
    exp_addr[0] = 32'h100; exp_addr[1] = 32'h200; exp_addr[2] = 32'h100; exp_addr[3] = 32'h200;
    prev = 2'b00;
    for (int k = 0; k < 5; k++) begin
      tick();
      req_i      = (k < 4) ? 2'b11 : 2'b00;
      m_gnt_i    = (k < 4);
      m_rvalid_i = (k > 0);
      m_rdata_i  = 32'h1000 + k;
      #1;
      if (k < 4) begin
        checks++;
        if (gnt_o !== exp_gnt[k]) begin errors++; $display("FAIL rr_gnt[%0d] got %b exp %b", k, gnt_o, exp_gnt[k]); end
        checks++;
        if (m_addr_o !== exp_addr[k]) begin errors++; $display("FAIL rr_addr[%0d] got %h exp %h", k, m_addr_o, exp_addr[k]); end
      end
      if (k > 0) begin
        checks++;
        if (rvalid_o !== prev) begin errors++; $display("FAIL rr_rvalid[%0d] got %b exp %b", k, rvalid_o, prev); end
        checks++;
        if (rdata_o[prev[1]] !== (32'h1000 + k)) begin
          errors++; $display("FAIL rr_rdata[%0d] got %h exp %h", k, rdata_o[prev[1]], 32'h1000 + k);
        end
      end
      if (k < 4) prev = exp_gnt[k];
    end
    tick();
    m_rvalid_i = 1'b0;
    #1;
    checks++;
    if (outstanding_o !== 2'd0) begin errors++; $display("FAIL rr_drained got %0d exp 0", outstanding_o); end
  endtask

  task automatic test_stall_lock();
    for (int k = 0; k < 3; k++) begin
      tick();
      req_i = 2'b10; m_gnt_i = 1'b0;
      #1;
      checks++;
      if (m_req_o !== 1'b1 || m_addr_o !== 32'h200 || gnt_o !== 2'b00) begin
        errors++; $display("FAIL stall[%0d] got req=%b addr=%h gnt=%b exp 1 00000200 00", k, m_req_o, m_addr_o, gnt_o);
      end
    end
    tick();
    req_i = 2'b11;
    #1;
    checks++;
    if (m_addr_o !== 32'h200 || gnt_o !== 2'b00) begin
      errors++; $display("FAIL stall_lock_hold got addr=%h gnt=%b exp 00000200 00", m_addr_o, gnt_o);
    end
    checks++;
    if (m_we_o !== 1'b1 || m_be_o !== 4'h3 || m_wdata_o !== 32'hC0DE_0001) begin
      errors++; $display("FAIL stall_wphase got we=%b be=%h wdata=%h exp 1 3 c0de0001", m_we_o, m_be_o, m_wdata_o);
    end
    tick();
    m_gnt_i = 1'b1;
    #1;
    checks++;
    if (gnt_o !== 2'b10 || m_addr_o !== 32'h200) begin
      errors++; $display("FAIL stall_release got gnt=%b addr=%h exp 10 00000200", gnt_o, m_addr_o);
    end
    tick();
    req_i = 2'b00; m_gnt_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'h5555;
    #1;
    checks++;
    if (rvalid_o !== 2'b10) begin errors++; $display("FAIL stall_resp got %b exp 10", rvalid_o); end
    tick();
    m_rvalid_i = 1'b0;
  endtask

  task automatic test_response_routing();
    tick();
    req_i = 2'b01; m_gnt_i = 1'b1;
    #1;
    checks++;
    if (gnt_o !== 2'b01 || m_addr_o !== 32'h100) begin
      errors++; $display("FAIL route_g0 got gnt=%b addr=%h exp 01 00000100", gnt_o, m_addr_o);
    end
    tick();
    req_i = 2'b10;
    #1;
    checks++;
    if (gnt_o !== 2'b10 || m_addr_o !== 32'h200) begin
      errors++; $display("FAIL route_g1 got gnt=%b addr=%h exp 10 00000200", gnt_o, m_addr_o);
    end
    tick();
    req_i = 2'b00; m_gnt_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'hAAAA;
    #1;
    checks++;
    if (rvalid_o !== 2'b01 || rdata_o[0] !== 32'hAAAA || rdata_o[1] !== 32'h0) begin
      errors++; $display("FAIL route_r0 got rv=%b d0=%h d1=%h exp 01 0000aaaa 0", rvalid_o, rdata_o[0], rdata_o[1]);
    end
    tick();
    m_rdata_i = 32'hBBBB;
    #1;
    checks++;
    if (rvalid_o !== 2'b10 || rdata_o[1] !== 32'hBBBB || rdata_o[0] !== 32'h0) begin
      errors++; $display("FAIL route_r1 got rv=%b d1=%h d0=%h exp 10 0000bbbb 0", rvalid_o, rdata_o[1], rdata_o[0]);
    end
    tick();
    m_rvalid_i = 1'b0;
  endtask

  task automatic test_full_fifo();
    tick();
    req_i = 2'b11; m_gnt_i = 1'b1;
    #1;
    checks++;
    if (gnt_o !== 2'b01) begin errors++; $display("FAIL full_g0 got %b exp 01", gnt_o); end
    tick();
    #1;
    checks++;
    if (gnt_o !== 2'b10) begin errors++; $display("FAIL full_g1 got %b exp 10", gnt_o); end
    tick();
    m_rvalid_i = 1'b1; m_rdata_i = 32'h1111;
    #1;
    checks++;
    if (outstanding_o !== 2'd2 || m_req_o !== 1'b0 || gnt_o !== 2'b00) begin
      errors++; $display("FAIL full_block got out=%0d req=%b gnt=%b exp 2 0 00", outstanding_o, m_req_o, gnt_o);
    end
    checks++;
    if (rvalid_o !== 2'b01) begin errors++; $display("FAIL full_pop got %b exp 01", rvalid_o); end
    tick();
    m_rvalid_i = 1'b0;
    #1;
    checks++;
    if (outstanding_o !== 2'd1 || m_req_o !== 1'b1 || gnt_o !== 2'b01) begin
      errors++; $display("FAIL full_resume got out=%0d req=%b gnt=%b exp 1 1 01", outstanding_o, m_req_o, gnt_o);
    end
    tick();
    req_i = 2'b00; m_gnt_i = 1'b0; m_rvalid_i = 1'b1;
    #1;
    checks++;
    if (rvalid_o !== 2'b10) begin errors++; $display("FAIL full_drain0 got %b exp 10", rvalid_o); end
    tick();
    #1;
    checks++;
    if (rvalid_o !== 2'b01) begin errors++; $display("FAIL full_drain1 got %b exp 01", rvalid_o); end
    tick();
    m_rvalid_i = 1'b0;
    #1;
    checks++;
    if (outstanding_o !== 2'd0) begin errors++; $display("FAIL full_empty got %0d exp 0", outstanding_o); end
  endtask

  task automatic test_spurious();
    tick();
    m_rvalid_i = 1'b1; m_rdata_i = 32'hDEAD;
    #1;
    checks++;
    if (rvalid_o !== 2'b00 || err_o !== 1'b0) begin
      errors++; $display("FAIL spur_same got rv=%b err=%b exp 00 0", rvalid_o, err_o);
    end
    tick();
    m_rvalid_i = 1'b0;
    tick(); tick();
    #1;
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL spur_sticky got %b exp 1", err_o); end
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    #1;
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL spur_clear got %b exp 0", err_o); end
  endtask

  initial begin
    rst_ni = 1'b0; req_i = 2'b00; m_gnt_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = '0;
    addr_i[0] = 32'h100; addr_i[1] = 32'h200;
    we_i = 2'b10;
    be_i[0] = 4'hF; be_i[1] = 4'h3;
    wdata_i[0] = 32'hC0DE_0000; wdata_i[1] = 32'hC0DE_0001;
    test_reset();
    test_round_robin();
    test_stall_lock();
    test_response_routing();
    test_full_fifo();
    test_spurious();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
